// File: rtl/cpu_run_sequencer.sv
// Host-driven preload and run control for the single-cycle MIPS CPU.
// Streams header/data words into the memory load ports, then runs the CPU.
module cpu_run_sequencer #(
  parameter int ADDR_W     = 6,
  parameter int IMEM_WORDS = 64,
  parameter int RF_WORDS   = 32,
  parameter int DMEM_WORDS = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              host_valid,
  input  logic [31:0]       host_data,
  output logic              host_ready,
  input  logic              cpu_halt,
  output logic              ld_we_imem,
  output logic              ld_we_rf,
  output logic              ld_we_dmem,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [31:0]       ld_wdata,
  output logic              cpu_hold,
  output logic              cpu_start,
  output logic              busy,
  output logic              done,
  output logic [15:0]       cycles_run,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN
  } state_t;

  localparam logic [1:0] T_IMEM = 2'b00;
  localparam logic [1:0] T_RF   = 2'b01;
  localparam logic [1:0] T_DMEM = 2'b10;
  localparam logic [1:0] T_RUN  = 2'b11;

  localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W+1)'(IMEM_WORDS);
  localparam logic [ADDR_W:0] RF_LIM   = (ADDR_W+1)'(RF_WORDS);
  localparam logic [ADDR_W:0] DMEM_LIM = (ADDR_W+1)'(DMEM_WORDS);

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [13:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   limit_q, limit_d;
  logic [15:0]       budget_q, budget_d;
  logic              we_imem_q, we_imem_d;
  logic              we_rf_q, we_rf_d;
  logic              we_dmem_q, we_dmem_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [31:0]       ld_wdata_q, ld_wdata_d;
  logic              hold_q, hold_d;
  logic              start_q, start_d;
  logic              pend_q, pend_d;
  logic              done_q, done_d;
  logic [15:0]       cycles_q, cycles_d;
  logic              err_q, err_d;

  logic              fire;
  logic [1:0]        hdr_tgt;
  logic [13:0]       hdr_cnt;
  logic [15:0]       hdr_arg;
  logic [ADDR_W:0]   hdr_lim;
  logic              in_range;
  logic [15:0]       cyc_inc;

  assign fire    = host_valid && ready_q;
  assign hdr_tgt = host_data[31:30];
  assign hdr_cnt = host_data[29:16];
  assign hdr_arg = host_data[15:0];

  always_comb begin
    hdr_lim = IMEM_LIM;
    unique case (1'b1)
      hdr_tgt == T_RF:   hdr_lim = RF_LIM;
      hdr_tgt == T_DMEM: hdr_lim = DMEM_LIM;
      default:           hdr_lim = IMEM_LIM;
    endcase
  end

  assign in_range = {1'b0, addr_q} < limit_q;
  assign cyc_inc  = (cycles_q == 16'hFFFF) ? cycles_q
                                           : cycles_q + 16'd1;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    limit_d    = limit_q;
    budget_d   = budget_q;
    we_imem_d  = 1'b0;
    we_rf_d    = 1'b0;
    we_dmem_d  = 1'b0;
    ld_addr_d  = ld_addr_q;
    ld_wdata_d = ld_wdata_q;
    hold_d     = hold_q;
    start_d    = 1'b0;
    pend_d     = 1'b0;
    done_d     = pend_q;
    cycles_d   = cycles_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (fire) begin
          if (hdr_tgt == T_RUN) begin
            budget_d = hdr_arg;
            cycles_d = 16'd0;
            if (hdr_arg == 16'd0) begin
              pend_d = 1'b1;
            end else begin
              state_d = S_RUN;
              start_d = 1'b1;
              hold_d  = 1'b0;
            end
          end else if (hdr_cnt != 14'd0) begin
            state_d = S_LOAD;
            tgt_d   = hdr_tgt;
            cnt_d   = hdr_cnt;
            addr_d  = hdr_arg[ADDR_W-1:0];
            limit_d = hdr_lim;
          end
        end
      end
      S_LOAD: begin
        if (fire) begin
          ld_addr_d  = addr_q;
          ld_wdata_d = host_data;
          if (in_range) begin
            unique case (1'b1)
              tgt_q == T_RF:   we_rf_d   = 1'b1;
              tgt_q == T_DMEM: we_dmem_d = 1'b1;
              default:         we_imem_d = 1'b1;
            endcase
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - 14'd1;
          if (cnt_q == 14'd1) state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cycles_d = cyc_inc;
        // Budget hit and halt on the same edge collapse into one exit.
        if (cyc_inc == budget_q || cpu_halt) begin
          state_d = S_IDLE;
          hold_d  = 1'b1;
          pend_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        hold_d  = 1'b1;
      end
    endcase

    ready_d = (state_d != S_RUN);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ready_q    <= 1'b0;
      tgt_q      <= T_IMEM;
      cnt_q      <= '0;
      addr_q     <= '0;
      limit_q    <= '0;
      budget_q   <= '0;
      we_imem_q  <= 1'b0;
      we_rf_q    <= 1'b0;
      we_dmem_q  <= 1'b0;
      ld_addr_q  <= '0;
      ld_wdata_q <= '0;
      hold_q     <= 1'b1;
      start_q    <= 1'b0;
      pend_q     <= 1'b0;
      done_q     <= 1'b0;
      cycles_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      limit_q    <= limit_d;
      budget_q   <= budget_d;
      we_imem_q  <= we_imem_d;
      we_rf_q    <= we_rf_d;
      we_dmem_q  <= we_dmem_d;
      ld_addr_q  <= ld_addr_d;
      ld_wdata_q <= ld_wdata_d;
      hold_q     <= hold_d;
      start_q    <= start_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      cycles_q   <= cycles_d;
      err_q      <= err_d;
    end
  end

  assign host_ready = ready_q;
  assign ld_we_imem = we_imem_q;
  assign ld_we_rf   = we_rf_q;
  assign ld_we_dmem = we_dmem_q;
  assign ld_addr    = ld_addr_q;
  assign ld_wdata   = ld_wdata_q;
  assign cpu_hold   = hold_q;
  assign cpu_start  = start_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign cycles_run = cycles_q;
  assign err        = err_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Directed bench for cpu_run_sequencer: loads, runs, wrap, range error, resets.
module tb_cpu_run_sequencer;

  logic        clock;
  logic        reset;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;
  logic        cpu_halt;
  logic        ld_we_imem;
  logic        ld_we_rf;
  logic        ld_we_dmem;
  logic [5:0]  ld_addr;
  logic [31:0] ld_wdata;
  logic        cpu_hold;
  logic        cpu_start;
  logic        busy;
  logic        done;
  logic [15:0] cycles_run;
  logic        err;

  int n_chk;
  int n_fail;

  cpu_run_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .cpu_halt   (cpu_halt),
    .ld_we_imem (ld_we_imem),
    .ld_we_rf   (ld_we_rf),
    .ld_we_dmem (ld_we_dmem),
    .ld_addr    (ld_addr),
    .ld_wdata   (ld_wdata),
    .cpu_hold   (cpu_hold),
    .cpu_start  (cpu_start),
    .busy       (busy),
    .done       (done),
    .cycles_run (cycles_run),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [31:0] w);
    host_valid = 1'b1;
    host_data  = w;
    tick();
  endtask

  task automatic idle_in();
    host_valid = 1'b0;
    host_data  = 32'h0;
  endtask

  task automatic strobes(input string tag, input logic [2:0] exp);
    check(tag, {29'd0, ld_we_imem, ld_we_rf, ld_we_dmem},
          {29'd0, exp});
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b0;
    tick();
    check("ready_after_rst", host_ready, 1);
  endtask

  logic [31:0] prog [3];

  initial begin
    n_chk  = 0;
    n_fail = 0;
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0007;
    prog[2] = 32'h0109_5020;
    reset = 1'b1;
    cpu_halt = 1'b0;
    idle_in();
    #2;
    check("rst_hold", cpu_hold, 1);
    check("rst_ready", host_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_start", cpu_start, 0);
    check("rst_err", err, 0);
    check("rst_cycles", cycles_run, 0);
    check("rst_addr", ld_addr, 0);
    strobes("rst_we", 3'b000);
    release_reset();

    // imem: 3 words back-to-back at 0
    put(32'h0003_0000);
    check("im_busy", busy, 1);
    strobes("im_hdr_we", 3'b000);
    for (int i = 0; i < 3; i++) begin
      put(prog[i]);
      strobes("im_we", 3'b100);
      check("im_addr", ld_addr, i);
      check("im_data", ld_wdata, prog[i]);
      check("im_hold", cpu_hold, 1);
    end
    check("im_idle", busy, 0);
    idle_in();
    tick();
    strobes("im_we_off", 3'b000);
    check("im_err", err, 0);

    // rf: 2 words at 1 with a 2-cycle valid gap
    put(32'h4002_0001);
    put(32'h0000_000A);
    strobes("rf_we0", 3'b010);
    check("rf_addr0", ld_addr, 1);
    check("rf_data0", ld_wdata, 32'hA);
    idle_in();
    tick();
    strobes("rf_gap0", 3'b000);
    check("rf_gap_busy", busy, 1);
    tick();
    strobes("rf_gap1", 3'b000);
    put(32'h0000_000B);
    strobes("rf_we1", 3'b010);
    check("rf_addr1", ld_addr, 2);
    check("rf_data1", ld_wdata, 32'hB);
    check("rf_idle", busy, 0);
    idle_in();
    tick();
    strobes("rf_we_off", 3'b000);

    // run, budget 8
    put(32'hC000_0008);
    idle_in();
    check("r8_start", cpu_start, 1);
    check("r8_hold0", cpu_hold, 0);
    check("r8_ready0", host_ready, 0);
    check("r8_cyc0", cycles_run, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("r8_hold", cpu_hold, 0);
      check("r8_start_off", cpu_start, 0);
      check("r8_ready", host_ready, 0);
      check("r8_cyc", cycles_run, i);
      check("r8_done_early", done, 0);
      strobes("r8_we", 3'b000);
    end
    tick();
    check("r8_hold_up", cpu_hold, 1);
    check("r8_cyc8", cycles_run, 8);
    check("r8_done_not_yet", done, 0);
    check("r8_busy", busy, 0);
    tick();
    check("r8_done", done, 1);
    tick();
    check("r8_done_off", done, 0);
    check("r8_cyc_hold", cycles_run, 8);

    // run, budget 100, halt in run cycle 5
    put(32'hC000_0064);
    idle_in();
    check("rh_start", cpu_start, 1);
    check("rh_cyc0", cycles_run, 0);
    for (int i = 1; i <= 4; i++) tick();
    check("rh_cyc4", cycles_run, 4);
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    check("rh_cyc5", cycles_run, 5);
    check("rh_hold", cpu_hold, 1);
    check("rh_busy", busy, 0);
    tick();
    check("rh_done", done, 1);
    tick();
    check("rh_done_off", done, 0);

    // run, budget 0
    put(32'hC000_0000);
    idle_in();
    check("r0_start", cpu_start, 0);
    check("r0_hold", cpu_hold, 1);
    check("r0_busy", busy, 0);
    check("r0_cyc", cycles_run, 0);
    tick();
    check("r0_done", done, 1);
    check("r0_start1", cpu_start, 0);
    tick();
    check("r0_done_off", done, 0);

    // dmem wrap at 63, then out-of-range rf
    put(32'h8002_003F);
    put(32'h0000_0011);
    strobes("dm_we0", 3'b001);
    check("dm_addr0", ld_addr, 63);
    put(32'h0000_0022);
    strobes("dm_we1", 3'b001);
    check("dm_addr1", ld_addr, 0);
    check("dm_data1", ld_wdata, 32'h22);
    check("dm_err", err, 0);
    put(32'h4001_0020);
    put(32'h0000_0033);
    strobes("oor_we", 3'b000);
    check("oor_err", err, 1);
    idle_in();
    tick();
    check("oor_err_hold", err, 1);
    put(32'h0001_0005);
    put(32'h0000_0044);
    strobes("oor_next_we", 3'b100);
    check("oor_next_addr", ld_addr, 5);
    check("oor_sticky", err, 1);
    idle_in();
    tick();

    // reset mid-LOAD
    put(32'h0003_0010);
    put(32'h0000_0055);
    strobes("ml_we", 3'b100);
    check("ml_addr", ld_addr, 16);
    host_data = 32'h0000_0066;
    #3;
    reset = 1'b1;
    #1;
    idle_in();
    strobes("ml_rst_we", 3'b000);
    check("ml_rst_busy", busy, 0);
    check("ml_rst_hold", cpu_hold, 1);
    check("ml_rst_ready", host_ready, 0);
    check("ml_rst_err", err, 0);
    check("ml_rst_addr", ld_addr, 0);
    release_reset();
    put(32'h0001_0007);
    strobes("ml_new_hdr", 3'b000);
    put(32'h0000_0077);
    strobes("ml_new_we", 3'b100);
    check("ml_new_addr", ld_addr, 7);
    check("ml_new_data", ld_wdata, 32'h77);
    idle_in();
    tick();

    // reset mid-RUN
    put(32'hC000_0010);
    idle_in();
    check("mr_hold0", cpu_hold, 0);
    tick();
    tick();
    check("mr_cyc2", cycles_run, 2);
    #3;
    reset = 1'b1;
    #1;
    check("mr_rst_hold", cpu_hold, 1);
    check("mr_rst_busy", busy, 0);
    check("mr_rst_cyc", cycles_run, 0);
    check("mr_rst_done", done, 0);
    release_reset();
    put(32'hC000_0002);
    idle_in();
    check("mr_new_start", cpu_start, 1);
    check("mr_new_hold", cpu_hold, 0);
    tick();
    check("mr_new_cyc1", cycles_run, 1);
    tick();
    check("mr_new_end", cpu_hold, 1);
    check("mr_new_cyc2", cycles_run, 2);
    tick();
    check("mr_new_done", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
